// File: rtl/dcache_if.sv
// Signal bundle for the dcache: the CPU memory-stage port and the block memory port.
interface dcache_if;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITEDATA;
    logic         READ;
    logic         WRITE;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    // Environment side: CPU requests and memory responses.
    modport master (
        output ADDRESS, WRITEDATA, READ, WRITE, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_ADDRESS, MEM_WRITEDATA, MEM_READ, MEM_WRITE
    );

    // Cache side.
    modport slave (
        input  ADDRESS, WRITEDATA, READ, WRITE, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_ADDRESS, MEM_WRITEDATA, MEM_READ, MEM_WRITE
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with a 16-byte block
// write-back/fetch handshake toward data memory.
module dcache #(
    parameter int unsigned NUM_LINES = 8
) (
    input  logic    CLK,
    input  logic    RESET,
    dcache_if.slave bus
);
    localparam int unsigned IDX   = $clog2(NUM_LINES);
    localparam int unsigned TAGW  = 28 - IDX;
    localparam int unsigned WORDS = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        FETCH      = 2'd2
    } state_t;

    state_t               state_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAGW-1:0]      tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS];

    logic [IDX-1:0]  idx_c;
    logic [TAGW-1:0] tag_c;
    logic [1:0]      off_c;
    logic            req_c;
    logic            hit_c;
    logic            unused_byte_off;

    // Address decode and hit detection.
    assign idx_c           = bus.ADDRESS[IDX+3:4];
    assign tag_c           = bus.ADDRESS[31:IDX+4];
    assign off_c           = bus.ADDRESS[3:2];
    assign unused_byte_off = ^bus.ADDRESS[1:0];
    assign req_c           = bus.READ | bus.WRITE;
    assign hit_c           = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

    assign bus.BUSYWAIT      = (state_q != IDLE) || (req_c && !hit_c);
    assign bus.READDATA      = data_q[idx_c][off_c];
    assign bus.MEM_READ      = mem_read_q;
    assign bus.MEM_WRITE     = mem_write_q;
    // The victim block address comes from the stored tag, the refill from the CPU address.
    assign bus.MEM_ADDRESS   = (state_q == WRITE_BACK) ? {tag_q[idx_c], idx_c} : bus.ADDRESS[31:4];
    assign bus.MEM_WRITEDATA = {data_q[idx_c][3], data_q[idx_c][2], data_q[idx_c][1], data_q[idx_c][0]};

    // Control state, memory strobes and per-line valid/dirty bits.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_c && !hit_c) begin
                        if (dirty_q[idx_c]) begin
                            state_q     <= WRITE_BACK;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            mem_read_q <= 1'b1;
                        end
                    end else if (bus.WRITE && hit_c) begin
                        dirty_q[idx_c] <= 1'b1;
                    end
                end
                WRITE_BACK: begin
                    if (!bus.MEM_BUSYWAIT) begin
                        state_q     <= FETCH;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!bus.MEM_BUSYWAIT) begin
                        state_q        <= IDLE;
                        mem_read_q     <= 1'b0;
                        valid_q[idx_c] <= 1'b1;
                        dirty_q[idx_c] <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays: refilled on fetch completion, word-updated on a store hit.
    always_ff @(posedge CLK) begin
        if (state_q == FETCH && !bus.MEM_BUSYWAIT) begin
            tag_q[idx_c] <= tag_c;
            for (int w = 0; w < WORDS; w++) begin
                data_q[idx_c][w] <= bus.MEM_READDATA[32*w +: 32];
            end
        end else if (state_q == IDLE && bus.WRITE && hit_c) begin
            data_q[idx_c][off_c] <= bus.WRITEDATA;
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: 4-cycle block memory, flat coherent-memory reference and
// residency model predicting stall counts.
module tb_dcache;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    dcache_if bus ();

    dcache #(.NUM_LINES(8)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Block memory: busy 4 cycles per request, then completes on the next edge.
    logic [127:0] mem [256];
    bit           written [256];
    int           mcnt = 0;
    int           fetch_cnt = 0;
    int           wb_cnt = 0;
    int           both_cnt = 0;
    logic [27:0]  last_fetch_addr = '0;
    logic [27:0]  last_wb_addr = '0;
    logic [127:0] last_wb_data = '0;

    function automatic logic [127:0] mem_block(input logic [27:0] b);
        logic [127:0] r;
        if (written[b[7:0]]) return mem[b[7:0]];
        for (int w = 0; w < 4; w++) r[32*w +: 32] = {b, 2'(w), 2'b00};
        return r;
    endfunction

    assign bus.MEM_BUSYWAIT = (bus.MEM_READ || bus.MEM_WRITE) && (mcnt < 4);
    assign bus.MEM_READDATA = mem_block(bus.MEM_ADDRESS);

    always @(posedge clk) begin
        if (bus.MEM_READ && bus.MEM_WRITE) both_cnt <= both_cnt + 1;
        if (bus.MEM_READ || bus.MEM_WRITE) begin
            if (!bus.MEM_BUSYWAIT) begin
                mcnt <= 0;
                if (bus.MEM_WRITE) begin
                    mem[bus.MEM_ADDRESS[7:0]]     <= bus.MEM_WRITEDATA;
                    written[bus.MEM_ADDRESS[7:0]] <= 1'b1;
                    wb_cnt       <= wb_cnt + 1;
                    last_wb_addr <= bus.MEM_ADDRESS;
                    last_wb_data <= bus.MEM_WRITEDATA;
                end else begin
                    fetch_cnt       <= fetch_cnt + 1;
                    last_fetch_addr <= bus.MEM_ADDRESS;
                end
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    // Reference: CPU-visible memory is the last stored word, else backing memory.
    logic [31:0] ref_mem [logic [31:0]];
    bit          ref_valid [8];
    bit          ref_dirty [8];
    logic [24:0] ref_tag   [8];

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [31:0]  a;
        logic [127:0] blk;
        a = {addr[31:2], 2'b00};
        if (ref_mem.exists(a)) return ref_mem[a];
        blk = mem_block(addr[31:4]);
        return blk[32*addr[3:2] +: 32];
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        ref_mem.delete();
    endtask

    // One CPU access held until BUSYWAIT drops; returns observed and predicted results.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int stalls, output logic [31:0] rdata,
                          output int exp_stalls, output logic [31:0] exp_rdata);
        int unsigned idx;
        idx       = 32'(addr[6:4]);
        exp_rdata = ref_word(addr);
        if (ref_valid[idx] && ref_tag[idx] == addr[31:7]) begin
            exp_stalls = 0;
        end else begin
            exp_stalls     = ref_dirty[idx] ? 11 : 6;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = addr[31:7];
            ref_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_dirty[idx] = 1'b1;
            ref_mem[{addr[31:2], 2'b00}] = wdata;
        end
        bus.ADDRESS   = addr;
        bus.WRITEDATA = wdata;
        bus.READ      = rd;
        bus.WRITE     = wr;
        stalls = 0;
        #1;
        while (bus.BUSYWAIT && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rdata = bus.READDATA;
        @(negedge clk);
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ADDRESS = '0; bus.WRITEDATA = '0; bus.READ = 1'b0; bus.WRITE = 1'b0;
        ref_reset();
        repeat (3) @(negedge clk);
        vectors++; if (bus.BUSYWAIT !== 1'b0) begin errors++; $display("FAIL rst_busywait got %b want 0", bus.BUSYWAIT); end
        vectors++; if (bus.MEM_READ !== 1'b0) begin errors++; $display("FAIL rst_mem_read got %b want 0", bus.MEM_READ); end
        vectors++; if (bus.MEM_WRITE !== 1'b0) begin errors++; $display("FAIL rst_mem_write got %b want 0", bus.MEM_WRITE); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (fetch_cnt + wb_cnt !== 0) begin errors++; $display("FAIL idle_traffic got %0d want 0", fetch_cnt + wb_cnt); end
    endtask

    task automatic test_read_miss();
        int st, es; logic [31:0] rd, er; int f0;
        f0 = fetch_cnt;
        access(1'b1, 1'b0, 32'h40, '0, st, rd, es, er);
        vectors++; if (st !== 6) begin errors++; $display("FAIL s1_stalls got %0d want 6", st); end
        vectors++; if (fetch_cnt !== f0 + 1 || last_fetch_addr !== 28'h4) begin errors++; $display("FAIL s1_fetch got n=%0d addr=%h want n=%0d addr=0000004", fetch_cnt - f0, last_fetch_addr, 1); end
        vectors++; if (rd !== 32'h40) begin errors++; $display("FAIL s1_rdata got %h want 00000040", rd); end
        access(1'b1, 1'b0, 32'h44, '0, st, rd, es, er);
        vectors++; if (st !== 0 || rd !== 32'h44) begin errors++; $display("FAIL s1_hit got stalls=%0d data=%h want 0/00000044", st, rd); end
    endtask

    task automatic test_write_hit();
        int st, es; logic [31:0] rd, er; int t0;
        t0 = fetch_cnt + wb_cnt;
        access(1'b0, 1'b1, 32'h48, 32'hDEADBEEF, st, rd, es, er);
        vectors++; if (st !== 0) begin errors++; $display("FAIL s2_wr_stalls got %0d want 0", st); end
        access(1'b1, 1'b0, 32'h48, '0, st, rd, es, er);
        vectors++; if (st !== 0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL s2_readback got stalls=%0d data=%h want 0/deadbeef", st, rd); end
        vectors++; if (fetch_cnt + wb_cnt !== t0) begin errors++; $display("FAIL s2_no_mem got %0d want %0d", fetch_cnt + wb_cnt, t0); end
    endtask

    task automatic test_dirty_evict();
        int st, es; logic [31:0] rd, er;
        access(1'b1, 1'b0, 32'hC8, '0, st, rd, es, er);
        vectors++; if (st !== 11) begin errors++; $display("FAIL s3_stalls got %0d want 11", st); end
        vectors++; if (last_wb_addr !== 28'h4 || last_wb_data[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL s3_wb got addr=%h w2=%h want 0000004/deadbeef", last_wb_addr, last_wb_data[95:64]); end
        vectors++; if (last_fetch_addr !== 28'hC) begin errors++; $display("FAIL s3_fetch_addr got %h want 000000c", last_fetch_addr); end
        vectors++; if (rd !== 32'hC8) begin errors++; $display("FAIL s3_rdata got %h want 000000c8", rd); end
    endtask

    task automatic test_write_miss();
        int st, es; logic [31:0] rd, er; int w0;
        w0 = wb_cnt;
        access(1'b0, 1'b1, 32'h100, 32'h12345678, st, rd, es, er);
        vectors++; if (st !== 6 || wb_cnt !== w0) begin errors++; $display("FAIL s4_alloc got stalls=%0d wb=%0d want 6/0", st, wb_cnt - w0); end
        access(1'b1, 1'b0, 32'h180, '0, st, rd, es, er);
        vectors++; if (st !== 11) begin errors++; $display("FAIL s4_evict_stalls got %0d want 11", st); end
        vectors++; if (last_wb_addr !== 28'h10 || last_wb_data !== {32'h10C, 32'h108, 32'h104, 32'h12345678}) begin errors++; $display("FAIL s4_wb got addr=%h data=%h", last_wb_addr, last_wb_data); end
        vectors++; if (rd !== 32'h180) begin errors++; $display("FAIL s4_rdata got %h want 00000180", rd); end
    endtask

    task automatic test_reset_mid_fetch();
        int st, es; logic [31:0] rd, er; int f0;
        f0 = fetch_cnt;
        bus.ADDRESS = 32'h2A0; bus.READ = 1'b1; bus.WRITE = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (bus.MEM_READ !== 1'b1) begin errors++; $display("FAIL s5_in_fetch got %b want 1", bus.MEM_READ); end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.MEM_READ !== 1'b0) begin errors++; $display("FAIL s5_async_drop got %b want 0", bus.MEM_READ); end
        bus.READ = 1'b0;
        ref_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (fetch_cnt !== f0) begin errors++; $display("FAIL s5_no_complete got %0d want %0d", fetch_cnt, f0); end
        access(1'b1, 1'b0, 32'h2A0, '0, st, rd, es, er);
        vectors++; if (st !== 6 || fetch_cnt !== f0 + 1 || rd !== 32'h2A0) begin errors++; $display("FAIL s5_refetch got stalls=%0d fetches=%0d data=%h want 6/1/000002a0", st, fetch_cnt - f0, rd); end
    endtask

    task automatic test_read_write();
        int st, es; logic [31:0] rd, er; int w0;
        access(1'b1, 1'b0, 32'h184, '0, st, rd, es, er);
        vectors++; if (st !== 6) begin errors++; $display("FAIL s6_warm got %0d want 6", st); end
        access(1'b1, 1'b1, 32'h184, 32'hCAFEF00D, st, rd, es, er);
        vectors++; if (st !== 0) begin errors++; $display("FAIL s6_rw_stalls got %0d want 0", st); end
        access(1'b1, 1'b0, 32'h184, '0, st, rd, es, er);
        vectors++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL s6_rw_data got %h want cafef00d", rd); end
        w0 = wb_cnt;
        access(1'b1, 1'b0, 32'h004, '0, st, rd, es, er);
        vectors++; if (st !== 11 || wb_cnt !== w0 + 1 || last_wb_data[63:32] !== 32'hCAFEF00D) begin errors++; $display("FAIL s6_dirty got stalls=%0d wb=%0d w1=%h want 11/1/cafef00d", st, wb_cnt - w0, last_wb_data[63:32]); end
    endtask

    task automatic test_random();
        int st, es; logic [31:0] rd, er, addr, wd; int op;
        for (int n = 0; n < 250; n++) begin
            addr = 32'($urandom_range(0, 255)) << 2;
            wd   = $urandom;
            op   = $urandom_range(0, 2);
            access(op != 1, op != 0, addr, wd, st, rd, es, er);
            vectors++; if (st !== es) begin errors++; $display("FAIL rnd_stalls #%0d addr=%h got %0d want %0d", n, addr, st, es); end
            if (op == 0) begin
                vectors++; if (rd !== er) begin errors++; $display("FAIL rnd_rdata #%0d addr=%h got %h want %h", n, addr, rd, er); end
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        vectors++; if (both_cnt !== 0) begin errors++; $display("FAIL mem_rd_wr_overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_evict();
        test_write_miss();
        test_reset_mid_fetch();
        test_read_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache between the CPU's data-memory port and the block-organised data memory. It consumes the word address, write data and READ/WRITE strobes produced by the CPU's memory stage. It returns read data and a busy-wait that freezes the pipeline. On a miss it runs a write-back/fetch handshake with memory in 16-byte blocks.

## Interface
- `NUM_LINES`, 8: number of cache lines; power of two, at least 2. `IDX = log2(NUM_LINES)`; tag width `TAGW = 28 - IDX`.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `ADDRESS` in 32: CPU byte address. `[1:0]` ignored (word access only), `[3:2]` word offset, `[3+IDX:4]` index, `[31:4+IDX]` tag.
- `WRITEDATA` in 32: CPU store word.
- `READ` in 1: CPU load request, held until BUSYWAIT is low.
- `WRITE` in 1: CPU store request, held until BUSYWAIT is low.
- `READDATA` out 32: selected word of the indexed line.
- `BUSYWAIT` out 1: stalls the CPU.
- `MEM_ADDRESS` out 28: block address to memory (byte address `[31:4]`).
- `MEM_WRITEDATA` out 128: block to write back; word 0 in `[31:0]`.
- `MEM_READ` out 1: block fetch request.
- `MEM_WRITE` out 1: block write-back request.
- `MEM_READDATA` in 128: fetched block; word 0 in `[31:0]`.
- `MEM_BUSYWAIT` in 1: memory busy. Memory raises it combinationally in the cycle a request appears and lowers it in the cycle the transfer is complete.

## Operation
- Storage per line: valid bit, dirty bit, TAGW-bit tag, 4x32 data.
- `hit = valid[idx] && (tag[idx] == ADDRESS tag)`.
- FSM states:
  - IDLE
    - READ or WRITE with hit: no transition.
    - Miss with dirty line: go to WRITE_BACK.
    - Miss with clean or invalid line: go to FETCH.
  - WRITE_BACK
    - `MEM_WRITE=1`, `MEM_ADDRESS={tag[idx], idx}`, `MEM_WRITEDATA=data[idx]`.
    - On the edge where `MEM_BUSYWAIT=0`: go to FETCH.
  - FETCH
    - `MEM_READ=1`, `MEM_ADDRESS=ADDRESS[31:4]`.
    - On the edge where `MEM_BUSYWAIT=0`: `data[idx] <= MEM_READDATA`, tag loaded, `valid=1`, `dirty=0`, go to IDLE.
- Read hit in IDLE: `READDATA = data[idx][offset]`, combinational, same cycle.
- Write hit in IDLE: on the next edge, word `offset` of `data[idx]` takes WRITEDATA and `dirty[idx]` is set. The other three words are unchanged.
- Write miss: allocate (fetch) first. The store then completes as a write hit in IDLE.
- `READ && WRITE` together: treated as a write. READDATA still reflects the indexed word.
- MEM_READ and MEM_WRITE are never both high. Both are low in IDLE. In IDLE, MEM_ADDRESS and MEM_WRITEDATA are don't-care.
- `BUSYWAIT = (state != IDLE) || ((READ || WRITE) && !hit)`.
- READDATA is don't-care when no READ is active.

## Timing
- Reset (RESET=0, async) takes effect immediately:
  - All valid and dirty bits cleared; tags and data untouched.
  - State goes to IDLE; `MEM_READ=0`, `MEM_WRITE=0`.
  - BUSYWAIT follows its equation, so it is 0 with no request.
- Reset mid-WRITE_BACK or mid-FETCH: the request drops asynchronously, the line is not updated, and dirty data is discarded.
- Read hit: 0 stall cycles.
- Write hit: 0 stall cycles; data visible to a read in the following cycle.
- Clean miss, memory busy for L cycles: BUSYWAIT is high for 1 (IDLE detect) + L + 1 (FETCH completion edge) cycles, then low in IDLE once the hit is seen.
- Dirty miss: a write-back of L+1 cycles is added before FETCH.
- A request changing address while BUSYWAIT is high is a protocol violation and behaviour is undefined. The CPU holds ADDRESS/READ/WRITE stable while stalled.
- Index aliasing: two addresses with equal index and different tags evict each other. A dirty victim is always written back before the refill.
- No request in IDLE: no state change and no memory traffic.

## Test plan
Memory model for all scenarios: busy for 4 cycles per request, initialised with each word equal to its byte address.

1. Reset, then READ `0x0000_0040` -> BUSYWAIT high for 6 cycles, one FETCH with `MEM_ADDRESS=0x000_0004`, then `READDATA=0x0000_0040` with BUSYWAIT low. A repeat read of `0x44` hits with 0 stall and returns `0x0000_0044`.
2. WRITE `0xDEADBEEF` to `0x48` after scenario 1 -> 0 stall cycles; a read of `0x48` the next cycle returns `0xDEADBEEF`; no memory request is issued.
3. Then READ `0x0000_00C8` (same index, 8 lines, different tag) -> WRITE_BACK to block `0x004` carries `MEM_WRITEDATA[95:64]=0xDEADBEEF`, then FETCH of block `0x00C`. READDATA is `0x0000_00C8` after 1+5+5 stall cycles.
4. WRITE `0x1234_5678` to cold address `0x100` -> fetch, then the store completes. MEM_WRITE never asserted. A later eviction via `0x180` writes back a block with word 0 = `0x12345678` and words 1–3 = `0x104`, `0x108`, `0x10C`.
5. Drop RESET low 2 cycles into a FETCH -> MEM_READ goes low without waiting for a clock edge. After release, READ of the same address misses again and issues a full FETCH.
6. READ and WRITE both high on a hit -> the write is performed, dirty is set, 0 stall cycles.
